// File: rtl/dsc_stoch2bin_rx.sv
// Stochastic-to-binary receiver: counts ones over a window of up to 2^OW valid
// samples (or until early shutoff), then holds the result until the consumer accepts it.
module dsc_stoch2bin_rx #(
  parameter int SNG_WIDTH  = 6,
  parameter int NUM_INPUTS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              sn_in,
  input  logic                              sn_valid,
  input  logic                              eos,
  input  logic                              z_ready,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0]   z,
  output logic                              z_valid,
  output logic                              busy,
  output logic                              sat
);

  localparam int OW = NUM_INPUTS * SNG_WIDTH;
  localparam logic [OW:0] CNT_ONE     = (OW+1)'(1);
  localparam logic [OW:0] LAST_SAMPLE = {1'b0, {OW{1'b1}}};

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [OW:0]     samp_q, samp_d;
  logic [OW:0]     ones_q, ones_d;
  logic [OW-1:0]   z_q, z_d;
  logic            sat_q, sat_d;
  logic [OW:0]     ones_final;
  logic            last_sample;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      samp_q  <= '0;
      ones_q  <= '0;
      z_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      ones_q  <= ones_d;
      z_q     <= z_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    ones_d      = ones_q;
    z_d         = z_q;
    sat_d       = sat_q;
    // Ones count including the sample arriving this cycle, so a closing sample is counted.
    ones_final  = ones_q + (sn_valid && sn_in ? CNT_ONE : '0);
    last_sample = sn_valid && (samp_q == LAST_SAMPLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          samp_d  = '0;
          ones_d  = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (sn_valid) begin
          samp_d = samp_q + CNT_ONE;
          ones_d = ones_final;
        end
        if (last_sample || eos) begin
          state_d = HOLD;
          z_d     = ones_final[OW] ? {OW{1'b1}} : ones_final[OW-1:0];
          sat_d   = ones_final[OW];
        end
      end
      HOLD: begin
        if (z_ready) begin
          if (start) begin
            samp_d  = '0;
            ones_d  = '0;
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign z       = z_q;
  assign z_valid = (state_q == HOLD);
  assign busy    = (state_q == COUNT);
  assign sat     = sat_q;

endmodule

// File: tb/tb_dsc_stoch2bin_rx.sv
// Directed bench for dsc_stoch2bin_rx: a window-level reference model is compared
// against the DUT every cycle, with literal expectations pinning key results.
module tb_dsc_stoch2bin_rx;

  localparam int OW   = 12;
  localparam int FULL = 1 << OW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, sn_in = 1'b0, sn_valid = 1'b0, eos = 1'b0, z_ready = 1'b0;
  logic [OW-1:0] z;
  logic z_valid, busy, sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsc_stoch2bin_rx #(.SNG_WIDTH(6), .NUM_INPUTS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .sn_in(sn_in), .sn_valid(sn_valid),
    .eos(eos), .z_ready(z_ready), .z(z), .z_valid(z_valid), .busy(busy), .sat(sat)
  );

  // Reference model: 0 = idle, 1 = window open, 2 = result held
  int m_mode = 0, m_n = 0, m_ones = 0, m_z = 0;
  bit m_sat = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_n = 0; m_ones = 0; m_z = 0; m_sat = 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin m_n = 0; m_ones = 0; m_mode = 1; end
        1: begin
          if (sn_valid) begin
            m_n++;
            if (sn_in) m_ones++;
          end
          if ((sn_valid && m_n == FULL) || eos) begin
            m_z   = (m_ones > FULL - 1) ? FULL - 1 : m_ones;
            m_sat = (m_ones == FULL);
            m_mode = 2;
          end
        end
        default: if (z_ready) begin
          if (start) begin m_n = 0; m_ones = 0; m_mode = 1; end
          else m_mode = 0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_z", 32'(z), 32'(m_z));
    chk("cyc_z_valid", 32'(z_valid), 32'(m_mode == 2));
    chk("cyc_busy", 32'(busy), 32'(m_mode == 1));
    chk("cyc_sat", 32'(sat), 32'(m_sat));
  end

  task automatic drive(input bit s, input bit v, input bit b, input bit e, input bit r);
    start = s; sn_valid = v; sn_in = b; eos = e; z_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    bit v;
    $display("txn reset");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", 32'(z), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_z_valid", 32'(z_valid), 0);
    chk("rst_sat", 32'(sat), 0);
    rst = 1'b1;
    drive(0, 0, 0, 1, 1);
    chk("eos_idle_ignored", 32'(busy), 0);

    $display("txn all-ones window");
    drive(1, 0, 0, 0, 0);
    chk("s1_busy", 32'(busy), 1);
    for (int i = 0; i < FULL - 1; i++) drive(0, 1, 1, 0, 0);
    chk("s1_not_done", 32'(z_valid), 0);
    drive(0, 1, 1, 0, 0);
    chk("s1_latency", 32'(z_valid), 1);
    chk("s1_z", 32'(z), 4095);
    chk("s1_sat", 32'(sat), 1);
    drive(0, 0, 0, 0, 1);
    chk("s1_idle", 32'(busy | z_valid), 0);
    chk("s1_z_kept", 32'(z), 4095);

    $display("txn alternating window");
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < FULL; i++) drive(0, 1, (i % 2) == 0, 0, 0);
    chk("s2_z_valid", 32'(z_valid), 1);
    chk("s2_z", 32'(z), 2048);
    chk("s2_sat", 32'(sat), 0);
    drive(0, 0, 0, 0, 1);

    $display("txn gapped window");
    drive(1, 0, 0, 0, 0);
    cnt = 0;
    for (int c = 0; c < 7000 && cnt < FULL; c++) begin
      v = (c % 3) != 2;
      if (v) cnt++;
      drive(0, v, 1, 0, 0);
    end
    chk("s3_count", 32'(cnt), 4096);
    chk("s3_z_valid", 32'(z_valid), 1);
    chk("s3_z", 32'(z), 4095);
    chk("s3_sat", 32'(sat), 1);
    drive(0, 0, 0, 0, 1);

    $display("txn eos window");
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 99; i++) drive(0, 1, i < 37, 0, 0);
    chk("s4_open", 32'(busy), 1);
    drive(0, 1, 0, 1, 0);
    chk("s4_z_valid", 32'(z_valid), 1);
    chk("s4_z", 32'(z), 37);
    chk("s4_sat", 32'(sat), 0);

    $display("txn hold with start pulses");
    for (int i = 0; i < 10; i++) begin
      drive(i % 2 == 0, 1, 1, 1, 0);
      chk("s5_hold_z", 32'(z), 37);
      chk("s5_hold_valid", 32'(z_valid), 1);
    end
    drive(1, 0, 0, 0, 1);
    chk("s5_direct_busy", 32'(busy), 1);
    chk("s5_direct_valid", 32'(z_valid), 0);
    chk("s5_direct_z", 32'(z), 37);

    $display("txn reset mid-window");
    for (int i = 0; i < 2000; i++) drive(0, 1, 1, 0, 0);
    rst = 1'b0;
    #1;
    chk("s6_rst_z", 32'(z), 0);
    chk("s6_rst_valid", 32'(z_valid), 0);
    chk("s6_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1, 1, 0, 0);
    chk("s6_needs_start", 32'(busy), 0);

    $display("txn fresh count after reset");
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0);
    chk("s7_z", 32'(z), 10);
    chk("s7_valid", 32'(z_valid), 1);
    drive(1, 0, 0, 0, 1);

    $display("txn empty eos window");
    drive(0, 0, 1, 1, 0);
    chk("s8_z", 32'(z), 0);
    chk("s8_sat", 32'(sat), 0);
    chk("s8_valid", 32'(z_valid), 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
